// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op encodings, FSM states and divider constants for the HILO multiply/divide unit
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    // One-hot so that exactly one state bit is ever set
    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_MUL  = 4'b0010,
        ST_DIV  = 4'b0100,
        ST_DONE = 4'b1000
    } state_e;

    localparam int DIV_ITERS = 32;

endpackage

// File: rtl/muldiv_hilo_ctrl_if.sv
// rtl/muldiv_hilo_ctrl_if.sv - execute-stage op/operand bundle and HILO write-back signals
interface muldiv_hilo_ctrl_if;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [63:0] hilo_cur;
    logic        flush;
    logic        hilo_we;
    logic [63:0] hilo_wdata;
    logic        stall_o;
    logic        busy;

    modport master (
        output op_valid, op, rs_val, rt_val, hilo_cur, flush,
        input  hilo_we, hilo_wdata, stall_o, busy
    );

    modport slave (
        input  op_valid, op, rs_val, rt_val, hilo_cur, flush,
        output hilo_we, hilo_wdata, stall_o, busy
    );
endinterface

// File: rtl/div_iter.sv
// rtl/div_iter.sv - unsigned 32/32 radix-2 restoring divider, one quotient bit per cycle
module div_iter
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [5:0]  cnt;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvs;
    logic [32:0] shifted;
    logic [32:0] diff;

    // Partial remainder shifted left with the next dividend bit, and the trial subtraction
    always_comb begin
        shifted = {rem, quo[31]};
        diff    = shifted - {1'b0, dvs};
    end

    // Final iteration completes on the coming edge
    assign done      = (cnt == 6'd1);
    assign quotient  = quo;
    assign remainder = rem;

    // Iteration state: quotient bits shift in from the right as dividend bits shift out the left
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 6'd0;
            quo <= 32'd0;
            rem <= 32'd0;
            dvs <= 32'd0;
        end else if (abort) begin
            cnt <= 6'd0;
        end else if (start) begin
            cnt <= 6'(DIV_ITERS);
            quo <= dividend;
            rem <= 32'd0;
            dvs <= divisor;
        end else if (cnt != 6'd0) begin
            cnt <= cnt - 6'd1;
            if (!diff[32]) begin
                rem <= diff[31:0];
                quo <= {quo[30:0], 1'b1};
            end else begin
                rem <= shifted[31:0];
                quo <= {quo[30:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// rtl/muldiv_hilo_ctrl.sv - HILO multiply/divide/move controller; MDU_MUL_PIPE_EN registers the product
module muldiv_hilo_ctrl
    import mdu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    muldiv_hilo_ctrl_if.slave    bus
);

    state_e      state;
    logic        accept;
    logic        is_mt;
    logic        is_mul;
    logic        is_div;
    logic        is_signed;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] mul_prod;
    logic [63:0] mt_data;
    logic [31:0] dvd_abs;
    logic [31:0] dvs_abs;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic [63:0] div_data;

    logic        neg_q;
    logic        neg_r;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] dvd_raw;
`ifdef MDU_MUL_PIPE_EN
    logic [63:0] mul_res;
`endif

    // Decode and operand preparation for the accept cycle
    always_comb begin
        accept    = (state == ST_IDLE) && bus.op_valid && !bus.flush && (bus.op <= 3'd5);
        is_mt     = (bus.op == OP_MTHI) || (bus.op == OP_MTLO);
        is_mul    = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
        is_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
        is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        prod_s    = {{32{bus.rs_val[31]}}, bus.rs_val} * {{32{bus.rt_val[31]}}, bus.rt_val};
        prod_u    = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};
        mul_prod  = (bus.op == OP_MULT) ? prod_s : prod_u;
        mt_data   = (bus.op == OP_MTHI) ? {bus.rs_val, bus.hilo_cur[31:0]}
                                        : {bus.hilo_cur[63:32], bus.rs_val};
        dvd_abs   = (is_signed && bus.rs_val[31]) ? -bus.rs_val : bus.rs_val;
        dvs_abs   = (is_signed && bus.rt_val[31]) ? -bus.rt_val : bus.rt_val;
    end

    div_iter u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && is_div),
        .abort     (bus.flush),
        .dividend  (dvd_abs),
        .divisor   (dvs_abs),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Sign restoration and the divide-by-zero / signed-overflow overrides
    always_comb begin
        if (div_zero)
            div_data = {dvd_raw, 32'hFFFF_FFFF};
        else if (div_ovf)
            div_data = {32'd0, 32'h8000_0000};
        else
            div_data = {(neg_r ? -div_rem : div_rem), (neg_q ? -div_quo : div_quo)};
    end

    // Control FSM plus the per-op context captured at accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            dvd_raw  <= 32'd0;
`ifdef MDU_MUL_PIPE_EN
            mul_res  <= 64'd0;
`endif
        end else if (bus.flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        neg_q    <= is_signed && (bus.rs_val[31] ^ bus.rt_val[31]);
                        neg_r    <= is_signed && bus.rs_val[31];
                        div_zero <= (bus.rt_val == 32'd0);
                        div_ovf  <= is_signed && (bus.rs_val == 32'h8000_0000)
                                              && (bus.rt_val == 32'hFFFF_FFFF);
                        dvd_raw  <= bus.rs_val;
`ifdef MDU_MUL_PIPE_EN
                        mul_res  <= mul_prod;
                        if (is_mul)
                            state <= ST_MUL;
`endif
                        if (is_div)
                            state <= ST_DIV;
                    end
                end
                ST_MUL:  state <= ST_IDLE;
                ST_DIV:  if (div_done) state <= ST_DONE;
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Write-back and stall; reset and flush silence both immediately
    always_comb begin
        bus.hilo_we    = 1'b0;
        bus.hilo_wdata = 64'd0;
        bus.stall_o    = 1'b0;
        if (!rst && !bus.flush) begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_mt) begin
                            bus.hilo_we    = 1'b1;
                            bus.hilo_wdata = mt_data;
                        end else if (is_mul) begin
`ifdef MDU_MUL_PIPE_EN
                            bus.stall_o    = 1'b1;
`else
                            bus.hilo_we    = 1'b1;
                            bus.hilo_wdata = mul_prod;
`endif
                        end else begin
                            bus.stall_o    = 1'b1;
                        end
                    end
                end
                ST_MUL: begin
`ifdef MDU_MUL_PIPE_EN
                    bus.hilo_we    = 1'b1;
                    bus.hilo_wdata = mul_res;
`endif
                end
                ST_DIV:  bus.stall_o = 1'b1;
                ST_DONE: begin
                    bus.hilo_we    = 1'b1;
                    bus.hilo_wdata = div_data;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = !rst && (state != ST_IDLE);

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb/tb_muldiv_hilo_ctrl.sv - vector table, corner sequences and random ops against an arithmetic model
module tb_muldiv_hilo_ctrl;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_hilo_ctrl_if bus ();

    muldiv_hilo_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [63:0] cur;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] rs,
                                          input logic [31:0] rt, input logic [63:0] cur);
        logic signed [63:0] a;
        logic signed [63:0] b;
        int q;
        int r;
        case (op)
            3'd0: begin
                a = $signed({{32{rs[31]}}, rs});
                b = $signed({{32{rt[31]}}, rt});
                return a * b;
            end
            3'd1: return {32'd0, rs} * {32'd0, rt};
            3'd2: begin
                if (rt == 0) return {rs, 32'hFFFF_FFFF};
                if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(rs) / $signed(rt);
                r = $signed(rs) % $signed(rt);
                return {r, q};
            end
            3'd3: begin
                if (rt == 0) return {rs, 32'hFFFF_FFFF};
                return {rs % rt, rs / rt};
            end
            3'd4: return {rs, cur[31:0]};
            default: return {cur[63:32], rs};
        endcase
    endfunction

    task automatic drive_op(input logic [2:0] op, input logic [31:0] rs,
                            input logic [31:0] rt, input logic [63:0] cur);
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.rs_val   = rs;
        bus.rt_val   = rt;
        bus.hilo_cur = cur;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [63:0] cur, input logic [63:0] exp);
        int stalls;
        bit got;
        @(negedge clk);
        drive_op(op, rs, rt, cur);
        #1;
        if (op >= 3'd4) begin
            chk({name, " we"}, 64'(bus.hilo_we), 64'd1);
            chk({name, " wdata"}, bus.hilo_wdata, exp);
            chk({name, " stall"}, 64'(bus.stall_o), 64'd0);
        end else if (op <= 3'd1) begin
`ifdef MDU_MUL_PIPE_EN
            chk({name, " accept stall"}, 64'(bus.stall_o), 64'd1);
            chk({name, " accept we"}, 64'(bus.hilo_we), 64'd0);
            @(negedge clk);
            bus.op_valid = 1'b0;
            #1;
`endif
            chk({name, " we"}, 64'(bus.hilo_we), 64'd1);
            chk({name, " wdata"}, bus.hilo_wdata, exp);
            chk({name, " stall"}, 64'(bus.stall_o), 64'd0);
        end else begin
            chk({name, " accept stall"}, 64'(bus.stall_o), 64'd1);
            chk({name, " accept we"}, 64'(bus.hilo_we), 64'd0);
            stalls = 1;
            got = 1'b0;
            @(negedge clk);
            bus.op_valid = 1'b0;
            for (int i = 0; i < 40; i++) begin
                #1;
                if (bus.hilo_we) begin
                    got = 1'b1;
                    chk({name, " wdata"}, bus.hilo_wdata, exp);
                    chk({name, " done stall"}, 64'(bus.stall_o), 64'd0);
                    break;
                end
                if (bus.stall_o) stalls++;
                @(negedge clk);
            end
            chk({name, " write seen"}, 64'(got), 64'd1);
            chk({name, " stall cycles"}, 64'(stalls), 64'd33);
        end
        @(negedge clk);
        bus.op_valid = 1'b0;
        #1;
        chk({name, " idle busy"}, 64'(bus.busy), 64'd0);
        chk({name, " idle we"}, 64'(bus.hilo_we), 64'd0);
    endtask

    task automatic watch_no_write(input string name, input int cycles);
        int writes;
        writes = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #1;
            if (bus.hilo_we) writes++;
        end
        chk(name, 64'(writes), 64'd0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] rrs;
        logic [31:0] rrt;
        logic [63:0] rcur;

        tbl[0] = '{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 64'd0, 64'hFFFF_FFFF_FFFF_FFFA};
        tbl[1] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD};
        tbl[2] = '{3'd3, 32'd100,       32'd0,         64'd0, 64'h0000_0064_FFFF_FFFF};
        tbl[3] = '{3'd5, 32'hAAAA_AAAA, 32'd0, 64'h1111_2222_3333_4444, 64'h1111_2222_AAAA_AAAA};
        tbl[4] = '{3'd4, 32'h1234_5678, 32'd0, 64'h1111_2222_3333_4444, 64'h1234_5678_3333_4444};
        tbl[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 64'h0000_0000_8000_0000};
        tbl[6] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFE_0000_0001};
        tbl[7] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 64'd0, 64'h0000_0001_FFFF_FFFD};
        tbl[8] = '{3'd2, 32'hFFFF_FFF8, 32'd0,         64'd0, 64'hFFFF_FFF8_FFFF_FFFF};
        tbl[9] = '{3'd3, 32'd9,         32'd4,         64'd0, 64'h0000_0001_0000_0002};

        rst = 1'b1;
        bus.op_valid = 1'b0;
        bus.op       = 3'd0;
        bus.rs_val   = 32'd0;
        bus.rt_val   = 32'd0;
        bus.hilo_cur = 64'd0;
        bus.flush    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset we", 64'(bus.hilo_we), 64'd0);
        chk("reset stall", 64'(bus.stall_o), 64'd0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset wdata", bus.hilo_wdata, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].cur, tbl[i].exp);

        // flush on the same cycle as op_valid: not accepted
        @(negedge clk);
        drive_op(3'd4, 32'hDEAD_BEEF, 32'd0, 64'd0);
        bus.flush = 1'b1;
        #1;
        chk("flush+valid we", 64'(bus.hilo_we), 64'd0);
        chk("flush+valid stall", 64'(bus.stall_o), 64'd0);
        @(negedge clk);
        drive_op(3'd2, 32'd50, 32'd3, 64'd0);
        #1;
        chk("flush+div stall", 64'(bus.stall_o), 64'd0);
        @(negedge clk);
        bus.op_valid = 1'b0;
        bus.flush = 1'b0;
        #1;
        chk("flush+div busy", 64'(bus.busy), 64'd0);

        // reserved op code is ignored
        @(negedge clk);
        drive_op(3'd6, 32'd5, 32'd5, 64'd0);
        #1;
        chk("op6 we", 64'(bus.hilo_we), 64'd0);
        chk("op6 stall", 64'(bus.stall_o), 64'd0);
        @(negedge clk);
        bus.op_valid = 1'b0;
        #1;
        chk("op6 busy", 64'(bus.busy), 64'd0);

        // flush at iteration 10 of a divide
        @(negedge clk);
        drive_op(3'd2, 32'd100, 32'd7, 64'd0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus.op_valid = 1'b0;
        end
        #1;
        chk("pre-flush stall", 64'(bus.stall_o), 64'd1);
        bus.flush = 1'b1;
        #1;
        chk("flush stall drop", 64'(bus.stall_o), 64'd0);
        chk("flush we", 64'(bus.hilo_we), 64'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        chk("post-flush busy", 64'(bus.busy), 64'd0);
        chk("post-flush stall", 64'(bus.stall_o), 64'd0);
        watch_no_write("post-flush writes", 40);
        run_op("multu after flush", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFE_0000_0001);

        // reset at iteration 20 of a DIVU
        @(negedge clk);
        drive_op(3'd3, 32'd1000, 32'd3, 64'd0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bus.op_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("mid-div reset we", 64'(bus.hilo_we), 64'd0);
        chk("mid-div reset stall", 64'(bus.stall_o), 64'd0);
        chk("mid-div reset busy", 64'(bus.busy), 64'd0);
        chk("mid-div reset wdata", bus.hilo_wdata, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        watch_no_write("post-reset writes", 40);
        run_op("divu after reset", 3'd3, 32'd9, 32'd4, 64'd0, 64'h0000_0001_0000_0002);

        // random ops against the arithmetic model
        for (int n = 0; n < 24; n++) begin
            rop  = 3'($urandom_range(0, 5));
            rrs  = $urandom;
            rrt  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rrt = 32'($urandom_range(1, 9));
            rcur = {$urandom, $urandom};
            run_op($sformatf("rnd%0d op%0d", n, rop), rop, rrs, rrt, rcur, model(rop, rrs, rrt, rcur));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo_ctrl.md
MULDIV_HILO_CTRL -- requirements
Module: muldiv_hilo_ctrl

Interface
REQ-001 SHALL have no parameters; data width is fixed at 32 bits, with a 64-bit HILO.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on posedge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port op_valid, input, 1, the execute-stage HILO-class instruction is valid this cycle.
REQ-005 SHALL have port op, input, 3, encoding MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; values 6 and 7 are ignored.
REQ-006 SHALL have ports rs_val and rt_val, input, 32 each, the operands.
REQ-007 SHALL have port hilo_cur, input, 64, the current HILO contents, used for MTHI/MTLO merge.
REQ-008 SHALL have port flush, input, 1, which cancels any accepted or in-flight operation.
REQ-009 SHALL have port hilo_we, output, 1, the HILO write enable.
REQ-010 SHALL have port hilo_wdata, output, 64, the HILO write data, {hi,lo}.
REQ-011 SHALL have port stall_o, output, 1, which holds the pipeline while a result is pending.
REQ-012 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-013 SHALL use the states IDLE, MUL, DIV and DONE, with exactly one state active at a time.
REQ-014 An op is accepted only in IDLE, with op_valid=1, flush=0 and op<=5; in all other cycles op_valid is ignored.
REQ-015 MTHI SHALL assert hilo_we combinationally in the accept cycle, with wdata = {rs_val, hilo_cur[31:0]}, stall_o=0, and no state change.
REQ-016 MTLO SHALL behave as MTHI, with wdata = {hilo_cur[63:32], rs_val}.
REQ-017 MULT/MULTU SHALL produce the full 64-bit product, signed or unsigned, as {hi,lo}; latency per REQ-028.
REQ-018 DIV/DIVU accept at cycle N SHALL: assert stall_o in cycles N..N+32, run 32 iterations in DIV, enter DONE at N+33, and assert hilo_we=1 with wdata={remainder,quotient}, stall_o=0 at N+33, then return to IDLE at N+34.
REQ-019 Signed divide SHALL divide absolute values; the quotient is negated when the operand signs differ, and the remainder takes the dividend's sign.
REQ-020 Divide by zero SHALL still take the full latency, and write quotient=0xFFFFFFFF and remainder=dividend.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL write quotient=0x80000000 and remainder=0.
REQ-022 flush=1 in any state SHALL force IDLE on the next edge, suppress hilo_we in that cycle, and drop stall_o combinationally.
REQ-023 flush and op_valid in the same cycle SHALL result in the op not being accepted.
REQ-024 hilo_we SHALL be high for at most one cycle per accepted op, and never while stall_o=1.

Reset
REQ-025 Asserting rst SHALL immediately force state=IDLE, hilo_we=0, stall_o=0, busy=0, hilo_wdata=0, and clear the iteration counter.
REQ-026 Reset mid-divide SHALL discard the operation with no HILO write.
REQ-027 On the first edge after rst falls, the block SHALL accept ops normally.

Configuration
REQ-028 The macro MDU_MUL_PIPE_EN SHALL select the multiply timing:
- Defined: the product is registered; the accept cycle has stall_o=1 and the state moves to MUL; the next cycle has hilo_we=1, stall_o=0 and the state moves to IDLE.
- Undefined: the product is combinational; hilo_we=1 in the accept cycle, stall_o=0, and the state stays in IDLE.

Structure
REQ-029 Package mdu_pkg SHALL hold the op encodings, the state enum, and DIV_ITERS=32.
REQ-030 Sub-module div_iter SHALL contain the radix-2 restoring divider: unsigned 32/32, with start/done and a 6-bit counter.
REQ-031 Sign handling, the special cases of REQ-020 and REQ-021, and the FSM SHALL reside in muldiv_hilo_ctrl.
REQ-032 muldiv_hilo_ctrl SHALL contain no HILO storage; it drives an external HILO register through hilo_we and hilo_wdata.

Verification
REQ-033 MULT with rs=0xFFFFFFFE (-2) and rt=0x00000003 SHALL write hilo_wdata=0xFFFFFFFF_FFFFFFFA, in the accept cycle (macro undefined) or one cycle later (macro defined).
REQ-034 DIV with rs=0xFFFFFFF9 (-7) and rt=2 SHALL hold stall_o high for 33 cycles, then write hi=0xFFFFFFFF and lo=0xFFFFFFFD.
REQ-035 DIVU with rs=100 and rt=0 SHALL, after 33 stall cycles, write {100, 0xFFFFFFFF}.
REQ-036 With hilo_cur=0x11112222_33334444, MTLO with rs=0xAAAAAAAA SHALL write 0x11112222_AAAAAAAA in one cycle with no stall.
REQ-037 DIV accepted, then flush asserted at iteration 10 SHALL drop stall_o, raise no hilo_we, and leave the block in IDLE; a following MULTU with 0xFFFFFFFF x 0xFFFFFFFF SHALL write 0xFFFFFFFE_00000001.
REQ-038 rst asserted at iteration 20 of a DIVU SHALL immediately zero all outputs; no write SHALL occur afterwards, and the next DIVU with 9/4 SHALL write {1,2}.
